// File: rtl/softreg_param_loader_pkg.sv
// SoftReg loader shared definitions.
// Register map, loader states, latched config bundle.
package softreg_param_loader_pkg;

  localparam logic [31:0] SR_N_VERT           = 32'h0000_0000;
  localparam logic [31:0] SR_N_INEDGES        = 32'h0000_0008;
  localparam logic [31:0] SR_VADDR            = 32'h0000_0010;
  localparam logic [31:0] SR_IEADDR           = 32'h0000_0018;
  localparam logic [31:0] SR_WRITE_ADDR0      = 32'h0000_0020;
  localparam logic [31:0] SR_WRITE_ADDR1      = 32'h0000_0028;
  localparam logic [31:0] SR_N_ROUNDS         = 32'h0000_0030;
  localparam logic [31:0] SR_DONE_READ_PARAMS = 32'h0000_0038;
  localparam logic [31:0] SR_DONE_ALL         = 32'h0000_0040;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_GAP,
    S_POLL_WAIT,
    S_READ,
    S_WAIT_RESP,
    S_DONE,
    S_ERROR
  } ldr_state_e;

  typedef struct packed {
    logic [63:0] n_vert;
    logic [63:0] n_inedges;
    logic [63:0] vaddr;
    logic [63:0] ieaddr;
    logic [63:0] waddr0;
    logic [63:0] waddr1;
    logic [63:0] n_rounds;
  } ldr_cfg_t;

endpackage

// File: rtl/softreg_param_loader_timer.sv
// Loadable 16-bit down-counter.
// Shared by the gap, poll-delay and response-timeout waits.
module srl_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        expired
);

  logic [15:0] count;

  // load wins; otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 16'd1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/softreg_param_loader.sv
// Host-side SoftReg setup sequencer for PageRank.
// Issues the 8-write setup, polls DONE_ALL, returns the sum.
module softreg_param_loader
  import softreg_param_loader_pkg::*;
#(
  parameter int unsigned WRITE_GAP    = 1,
  parameter int unsigned POLL_DELAY   = 64,
  parameter int unsigned RESP_TIMEOUT = 1024,
  parameter int unsigned MAX_POLLS    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] cfg_n_vert,
  input  logic [63:0] cfg_n_inedges,
  input  logic [63:0] cfg_vaddr,
  input  logic [63:0] cfg_ieaddr,
  input  logic [63:0] cfg_waddr0,
  input  logic [63:0] cfg_waddr1,
  input  logic [63:0] cfg_n_rounds,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [63:0] result,
  output logic        softreg_req_valid,
  output logic        softreg_req_isWrite,
  output logic [31:0] softreg_req_addr,
  output logic [63:0] softreg_req_data,
  input  logic        softreg_resp_valid,
  input  logic [63:0] softreg_resp_data
);

  // timer holds N-1 so the wait lasts exactly N cycles
  localparam logic [15:0] T_GAP =
    (WRITE_GAP > 0) ? 16'(WRITE_GAP - 1) : 16'd0;
  localparam logic [15:0] T_POLL =
    (POLL_DELAY > 0) ? 16'(POLL_DELAY - 1) : 16'd0;
  localparam logic [15:0] T_RESP =
    (RESP_TIMEOUT > 0) ? 16'(RESP_TIMEOUT - 1) : 16'd0;
  localparam logic [7:0] POLL_MAX = 8'(MAX_POLLS);

  ldr_state_e  state, state_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  polls, polls_n;
  ldr_cfg_t    cfg_in, cfg_q, cfg_src;
  logic        cap_cfg, cap_res;
  logic        tmr_load, tmr_exp;
  logic [15:0] tmr_val;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic        req_v_d, req_w_d;
  logic [31:0] req_a_d;
  logic [63:0] req_d_d;
  logic        busy_d;

  assign cfg_in = {cfg_n_vert, cfg_n_inedges,
                   cfg_vaddr, cfg_ieaddr,
                   cfg_waddr0, cfg_waddr1,
                   cfg_n_rounds};

  // first write is built in the start cycle, before the latch
  assign cfg_src = cap_cfg ? cfg_in : cfg_q;

  srl_timer u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  // state register and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= S_IDLE;
      idx                 <= '0;
      polls               <= '0;
      cfg_q               <= '0;
      result              <= '0;
      error               <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      softreg_req_valid   <= 1'b0;
      softreg_req_isWrite <= 1'b0;
      softreg_req_addr    <= '0;
      softreg_req_data    <= '0;
    end else begin
      state               <= state_n;
      idx                 <= idx_n;
      polls               <= polls_n;
      busy                <= busy_d;
      done                <= (state_n == S_DONE);
      softreg_req_valid   <= req_v_d;
      softreg_req_isWrite <= req_w_d;
      softreg_req_addr    <= req_a_d;
      softreg_req_data    <= req_d_d;
      if (cap_cfg) begin
        cfg_q  <= cfg_in;
        result <= '0;
        error  <= 1'b0;
      end else begin
        if (cap_res) result <= softreg_resp_data;
        if (state_n == S_ERROR) error <= 1'b1;
      end
    end
  end

  // next state, counters and timer loads
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    polls_n  = polls;
    cap_cfg  = 1'b0;
    cap_res  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_WRITE;
          idx_n   = '0;
          polls_n = '0;
          cap_cfg = 1'b1;
        end
      end
      S_WRITE: begin
        if (idx == 3'd7) begin
          if (POLL_DELAY == 0) begin
            state_n = S_READ;
          end else begin
            state_n  = S_POLL_WAIT;
            tmr_load = 1'b1;
            tmr_val  = T_POLL;
          end
        end else begin
          idx_n = idx + 3'd1;
          if (WRITE_GAP == 0) begin
            state_n = S_WRITE;
          end else begin
            state_n  = S_GAP;
            tmr_load = 1'b1;
            tmr_val  = T_GAP;
          end
        end
      end
      S_GAP: begin
        if (tmr_exp) state_n = S_WRITE;
      end
      S_POLL_WAIT: begin
        if (tmr_exp) state_n = S_READ;
      end
      S_READ: begin
        polls_n  = polls + 8'd1;
        state_n  = S_WAIT_RESP;
        tmr_load = 1'b1;
        tmr_val  = T_RESP;
      end
      S_WAIT_RESP: begin
        // a response on the expiry cycle still counts
        if (softreg_resp_valid) begin
          cap_res = 1'b1;
          state_n = S_DONE;
        end else if (tmr_exp) begin
          state_n = (polls < POLL_MAX) ? S_READ : S_ERROR;
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_ERROR: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // setup write pair for the upcoming write index
  always_comb begin
    wr_addr = SR_N_VERT;
    wr_data = cfg_src.n_vert;
    unique case (idx_n)
      3'd0: begin
        wr_addr = SR_N_VERT;
        wr_data = cfg_src.n_vert;
      end
      3'd1: begin
        wr_addr = SR_N_INEDGES;
        wr_data = cfg_src.n_inedges;
      end
      3'd2: begin
        wr_addr = SR_VADDR;
        wr_data = cfg_src.vaddr;
      end
      3'd3: begin
        wr_addr = SR_IEADDR;
        wr_data = cfg_src.ieaddr;
      end
      3'd4: begin
        wr_addr = SR_WRITE_ADDR0;
        wr_data = cfg_src.waddr0;
      end
      3'd5: begin
        wr_addr = SR_WRITE_ADDR1;
        wr_data = cfg_src.waddr1;
      end
      3'd6: begin
        wr_addr = SR_N_ROUNDS;
        wr_data = cfg_src.n_rounds;
      end
      3'd7: begin
        wr_addr = SR_DONE_READ_PARAMS;
        wr_data = '0;
      end
    endcase
  end

  // request and busy values for the next cycle
  always_comb begin
    req_v_d = 1'b0;
    req_w_d = 1'b0;
    req_a_d = '0;
    req_d_d = '0;
    busy_d  = 1'b1;
    if (state_n == S_WRITE) begin
      req_v_d = 1'b1;
      req_w_d = 1'b1;
      req_a_d = wr_addr;
      req_d_d = wr_data;
    end else if (state_n == S_READ) begin
      req_v_d = 1'b1;
      req_a_d = SR_DONE_ALL;
    end
    if (state_n == S_IDLE || state_n == S_DONE ||
        state_n == S_ERROR)
      busy_d = 1'b0;
  end

endmodule
